// File: rtl/leds_word_serializer.sv
// MSB-first parallel-to-serial transmitter feeding the LED line shift register (dout/dout_ena).
// Optional feature: define SERIAL_PARITY_EN to append an even-parity bit after the data bits.
module leds_word_serializer #(
   parameter int WORD_WIDTH = 18,
   parameter int BIT_PERIOD = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  dout,
   output logic                  dout_ena,
   output logic                  busy,
   output logic                  done
);

`ifdef SERIAL_PARITY_EN
   localparam int N = WORD_WIDTH + 1;
`else
   localparam int N = WORD_WIDTH;
`endif
   localparam int BW = $clog2(N);
   localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [1:0]    state;
   logic [N-1:0]  shreg;
   logic [N-1:0]  load_word;
   logic [CW-1:0] per_cnt;
   logic [BW-1:0] bit_cnt;
   logic [GW-1:0] gap_cnt;
   logic          accept;
   logic          strobe;
   logic          last_bit;

   // The parity bit rides in the LSB of the shift register so it leaves after the data bits.
`ifdef SERIAL_PARITY_EN
   assign load_word = {word_in, ^word_in};
`else
   assign load_word = word_in;
`endif

   assign accept   = word_valid & word_ready;
   assign strobe   = (state == ST_SHIFT) && (per_cnt == CNT_LAST);
   assign last_bit = (bit_cnt == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         per_cnt <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shreg   <= load_word;
                  per_cnt <= '0;
                  bit_cnt <= BIT_LAST;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (strobe) begin
                  per_cnt <= '0;
                  shreg   <= {shreg[N-2:0], 1'b0};
                  if (last_bit) begin
                     gap_cnt <= '0;
                     state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end else begin
                  per_cnt <= per_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only, so async reset clears them in the same cycle.
   assign word_ready = (state == ST_IDLE);
   assign busy       = (state == ST_SHIFT) || (state == ST_GAP);
   assign dout       = (state == ST_SHIFT) && shreg[N-1];
   assign dout_ena   = strobe;
   assign done       = strobe && last_bit;

endmodule

// File: tb/tb_leds_word_serializer.sv
// Directed bench for leds_word_serializer: a default-timed instance and a BIT_PERIOD=1/GAP=0 instance,
// each observed by an LED line receiver model. Honours SERIAL_PARITY_EN when defined.
module tb_leds_word_serializer;
   localparam int W = 18;
`ifdef SERIAL_PARITY_EN
   localparam int NB = W + 1;
   localparam logic [NB-1:0] F_EXP = {18'h00007, 1'b1};
`else
   localparam int NB = W;
   localparam logic [NB-1:0] F_EXP = 18'h00007;
`endif

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [W-1:0] word_in = '0;
   logic         word_valid = 1'b0;
   logic         word_ready, dout, dout_ena, busy, done;
   logic [W-1:0] f_word_in = '0;
   logic         f_word_valid = 1'b0;
   logic         f_word_ready, f_dout, f_dout_ena, f_busy, f_done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   leds_word_serializer #(.WORD_WIDTH(W), .BIT_PERIOD(4), .GAP_CYCLES(2)) dut (
      .clk(clk), .rstn(rstn), .word_in(word_in), .word_valid(word_valid),
      .word_ready(word_ready), .dout(dout), .dout_ena(dout_ena), .busy(busy), .done(done));

   leds_word_serializer #(.WORD_WIDTH(W), .BIT_PERIOD(1), .GAP_CYCLES(0)) dut_fast (
      .clk(clk), .rstn(rstn), .word_in(f_word_in), .word_valid(f_word_valid),
      .word_ready(f_word_ready), .dout(f_dout), .dout_ena(f_dout_ena), .busy(f_busy), .done(f_done));

   // clock / cycle index
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // LED line receiver models and scoreboard, sampled on the falling edge
   logic [NB-1:0] line = '0;
   logic [NB-1:0] f_line = '0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  got_q[$];
   int            st_q[$];
   int            acc_q[$];
   int            f_st_q[$];
   int            done_cyc = -1, done_cnt = 0;
   int            f_done_cyc = -1, f_done_cnt = 0;
   logic          f_last_bit = 1'b0;

   always @(negedge clk) begin
      if (word_valid && word_ready) acc_q.push_back(cyc);
      if (dout_ena) begin
         st_q.push_back(cyc);
         line = {line[NB-2:0], dout};
      end
      if (done) begin
         got_q.push_back(line[NB-1 -: W]);
         done_cyc = cyc;
         done_cnt++;
      end
      if (f_dout_ena) begin
         f_st_q.push_back(cyc);
         f_line = {f_line[NB-2:0], f_dout};
         f_last_bit = f_dout;
      end
      if (f_done) begin
         f_done_cyc = cyc;
         f_done_cnt++;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w, output int a);
      int n = 0;
      while (!word_ready && n < 200) begin tick(); n++; end
      checks++;
      if (word_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_ready: word_ready=%b required 1 within 200 cycles", word_ready);
      end
      word_in = w;
      word_valid = 1'b1;
      a = cyc;
      exp_q.push_back(w);
      tick();
      word_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 300) begin tick(); n++; end
      checks++;
      if (done_cnt < target) begin
         failures++;
         $display("FAIL done_timeout: done_cnt=%0d required %0d", done_cnt, target);
      end
   endtask

   task automatic wait_ready(output int rc);
      int n = 0;
      while (!word_ready && n < 100) begin tick(); n++; end
      rc = cyc;
      checks++;
      if (word_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_timeout: word_ready=%b required 1", word_ready);
      end
   endtask

   task automatic clear_mon();
      st_q.delete();
      acc_q.delete();
      got_q.delete();
      exp_q.delete();
   endtask

   // tests
   task automatic test_reset();
      rstn = 1'b0;
      word_valid = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({dout, dout_ena, busy, done, word_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_idle: dout,ena,busy,done,ready=%b required 00001", {dout, dout_ena, busy, done, word_ready});
         end
      end
      checks++;
      if (st_q.size() !== 0) begin
         failures++;
         $display("FAIL reset_no_strobe: strobes=%0d required 0", st_q.size());
      end
   endtask

   task automatic test_single();
      int a, rc, d0, v;
      clear_mon();
      d0 = done_cnt;
      send(18'h2A5C3, a);
      checks++;
      if ({busy, dout, word_ready} !== 3'b110) begin
         failures++;
         $display("FAIL single_first_bit: busy,dout,ready=%b required 110", {busy, dout, word_ready});
      end
      wait_done(d0 + 1);
      wait_ready(rc);
      checks++;
      if (acc_q.size() !== 1 || acc_q[0] !== a) begin
         failures++;
         $display("FAIL single_accept: accepts=%0d required 1 at cycle %0d", acc_q.size(), a);
      end
      checks++;
      if (st_q.size() !== NB) begin
         failures++;
         $display("FAIL single_strobe_count: got %0d required %0d", st_q.size(), NB);
      end
      for (int k = 1; k <= NB; k++) begin
         v = (k - 1 < st_q.size()) ? st_q[k-1] : -1;
         checks++;
         if (v !== a + 4 * k) begin
            failures++;
            $display("FAIL single_strobe_time k=%0d: cycle %0d required %0d", k, v, a + 4 * k);
         end
      end
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
         failures++;
         $display("FAIL single_word: got %h (n=%0d) required %h", (got_q.size() > 0) ? got_q[0] : '0, got_q.size(), exp_q[0]);
      end
      checks++;
      if (done_cyc !== a + 4 * NB) begin
         failures++;
         $display("FAIL single_done_time: cycle %0d required %0d", done_cyc, a + 4 * NB);
      end
      checks++;
      if (rc !== a + 4 * NB + 3) begin
         failures++;
         $display("FAIL single_ready_time: cycle %0d required %0d", rc, a + 4 * NB + 3);
      end
   endtask

   task automatic test_back_to_back();
      int a1, a2, t1, d0, n;
      clear_mon();
      d0 = done_cnt;
      n = 0;
      word_in = 18'h3FFFF;
      word_valid = 1'b1;
      while (!word_ready && n < 100) begin tick(); n++; end
      a1 = cyc;
      exp_q.push_back(18'h3FFFF);
      tick();
      word_in = 18'h00001;
      exp_q.push_back(18'h00001);
      wait_done(d0 + 1);
      t1 = done_cyc;
      n = 0;
      while (!word_ready && n < 100) begin tick(); n++; end
      a2 = cyc;
      tick();
      word_valid = 1'b0;
      wait_done(d0 + 2);
      checks++;
      if (a2 !== t1 + 3) begin
         failures++;
         $display("FAIL b2b_second_accept: cycle %0d required %0d", a2, t1 + 3);
      end
      checks++;
      if (acc_q.size() !== 2 || acc_q[0] !== a1 || acc_q[1] !== a2) begin
         failures++;
         $display("FAIL b2b_accepts: count %0d required 2 at %0d,%0d", acc_q.size(), a1, a2);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL b2b_word%0d: got %h required %h", i, (got_q.size() > i) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_ignore_busy();
      int a, rc, d0;
      clear_mon();
      d0 = done_cnt;
      send(18'h0F0F0, a);
      repeat (10) tick();
      word_in = 18'h12345;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      repeat (20) tick();
      word_valid = 1'b1;
      repeat (3) tick();
      word_valid = 1'b0;
      wait_done(d0 + 1);
      wait_ready(rc);
      repeat (5) tick();
      checks++;
      if (acc_q.size() !== 1) begin
         failures++;
         $display("FAIL ignore_accepts: got %0d required 1", acc_q.size());
      end
      checks++;
      if (st_q.size() !== NB) begin
         failures++;
         $display("FAIL ignore_strobes: got %0d required %0d", st_q.size(), NB);
      end
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== 18'h0F0F0) begin
         failures++;
         $display("FAIL ignore_word: got %h required 0f0f0", (got_q.size() > 0) ? got_q[0] : '0);
      end
   endtask

   task automatic test_reset_mid_word();
      int a, n, d0;
      clear_mon();
      d0 = done_cnt;
      send(18'h3FFFF, a);
      n = 0;
      while (st_q.size() < 7 && n < 100) begin tick(); n++; end
      n = 0;
      while (!dout_ena && n < 10) begin tick(); n++; end
      checks++;
      if ({dout_ena, dout, busy} !== 3'b111) begin
         failures++;
         $display("FAIL midrst_pre: ena,dout,busy=%b required 111", {dout_ena, dout, busy});
      end
      rstn = 1'b0;
      #1;
      checks++;
      if ({dout, dout_ena, busy, done} !== 4'b0000) begin
         failures++;
         $display("FAIL midrst_outputs: dout,ena,busy,done=%b required 0000", {dout, dout_ena, busy, done});
      end
      void'(exp_q.pop_back());
      repeat (3) tick();
      rstn = 1'b1;
      repeat (20) tick();
      checks++;
      if (word_ready !== 1'b1 || st_q.size() !== 7 || done_cnt !== d0) begin
         failures++;
         $display("FAIL midrst_after: ready=%b strobes=%0d dones=%0d required 1,7,%0d", word_ready, st_q.size(), done_cnt - d0, 0);
      end
   endtask

   task automatic test_fast_parity();
      int a, rc, d0, n, v;
      f_st_q.delete();
      d0 = f_done_cnt;
      f_word_in = 18'h00007;
      f_word_valid = 1'b1;
      a = cyc;
      tick();
      f_word_valid = 1'b0;
      n = 0;
      while (f_done_cnt <= d0 && n < 100) begin tick(); n++; end
      n = 0;
      while (!f_word_ready && n < 100) begin tick(); n++; end
      rc = cyc;
      checks++;
      if (f_st_q.size() !== NB) begin
         failures++;
         $display("FAIL fast_strobe_count: got %0d required %0d", f_st_q.size(), NB);
      end
      for (int k = 1; k <= NB; k++) begin
         v = (k - 1 < f_st_q.size()) ? f_st_q[k-1] : -1;
         checks++;
         if (v !== a + k) begin
            failures++;
            $display("FAIL fast_strobe_time k=%0d: cycle %0d required %0d", k, v, a + k);
         end
      end
      checks++;
      if (f_done_cyc !== a + NB) begin
         failures++;
         $display("FAIL fast_done_time: cycle %0d required %0d", f_done_cyc, a + NB);
      end
      checks++;
      if (rc !== a + NB + 1) begin
         failures++;
         $display("FAIL fast_ready_time: cycle %0d required %0d", rc, a + NB + 1);
      end
      checks++;
      if (f_line !== F_EXP || f_last_bit !== 1'b1) begin
         failures++;
         $display("FAIL fast_line: got %h last=%b required %h last=1", f_line, f_last_bit, F_EXP);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid_word();
      test_fast_parity();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
